// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// cp0_exc_ctrl : CP0 exception/interrupt control, SR/Cause/EPC/PRId, mfc0/mtc0/eret
// Revision 1.0
// ============================================================================
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VAL   = 32'h2022_1113,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcIn,
  input  logic        delaySlotIn,
  input  logic [4:0]  excCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] din,
  input  logic        eretIn,
  output logic [31:0] dout,
  output logic [31:0] EPCOut,
  output logic [31:0] excPC,
  output logic        Req
);

  localparam logic [4:0]  c_ADDR_SR    = 5'd12;
  localparam logic [4:0]  c_ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  c_ADDR_EPC   = 5'd14;
  localparam logic [4:0]  c_ADDR_PRID  = 5'd15;
  localparam logic [31:0] c_WORD_MASK  = 32'hFFFF_FFFC;

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_epc_wr;
  logic [31:0] w_epc_src;

  assign w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (excCodeIn != 5'd0) & ~r_exl;
  assign Req       = reset & (w_int_req | w_exc_req);
  assign excPC     = HANDLER_PC;

  // Delay-slot victims restart at the branch so the branch is re-executed.
  assign w_epc_src = delaySlotIn ? (pcIn - 32'd4) : pcIn;
  assign w_epc_wr  = we & (addr == c_ADDR_EPC);
  assign EPCOut    = w_epc_wr ? (din & c_WORD_MASK) : r_epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (Req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? 5'd0 : excCodeIn;
        r_bd      <= delaySlotIn;
        r_epc     <= w_epc_src & c_WORD_MASK;
      end else begin
        if (we && addr == c_ADDR_SR) begin
          r_im  <= din[15:10];
          r_exl <= din[1];
          r_ie  <= din[0];
        end
        if (w_epc_wr) begin
          r_epc <= din & c_WORD_MASK;
        end
        // Placed last so eret wins over a simultaneous mtc0 SR write to EXL.
        if (eretIn) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      c_ADDR_SR:    dout = {16'd0, r_im, 8'd0, r_exl, r_ie};
      c_ADDR_CAUSE: dout = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
      c_ADDR_EPC:   dout = r_epc;
      c_ADDR_PRID:  dout = PRID_VAL;
      default:      dout = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cp0_exc_ctrl : scoreboard bench for cp0_exc_ctrl
// Revision 1.0
// ============================================================================
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcIn;
  logic        delaySlotIn;
  logic [4:0]  excCodeIn;
  logic [5:0]  HWInt;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        eretIn;
  logic [31:0] dout;
  logic [31:0] EPCOut;
  logic [31:0] excPC;
  logic        Req;

  always #10 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .pcIn(pcIn), .delaySlotIn(delaySlotIn),
    .excCodeIn(excCodeIn), .HWInt(HWInt), .we(we), .addr(addr), .din(din),
    .eretIn(eretIn), .dout(dout), .EPCOut(EPCOut), .excPC(excPC), .Req(Req)
  );

  // sel: 0 = Req, 1 = dout at rd_addr, 2 = EPCOut, 3 = excPC
  typedef struct {
    string       tag;
    int          sel;
    logic [4:0]  rd_addr;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [4:0] a, input logic [31:0] e);
    sb_t ent;
    ent.tag = tag; ent.sel = sel; ent.rd_addr = a; ent.exp = e;
    sb_q.push_back(ent);
  endtask

  task automatic exp_req(input string tag, input logic e);
    push(tag, 0, 5'd0, {31'd0, e});
  endtask

  task automatic exp_rd(input string tag, input logic [4:0] a, input logic [31:0] e);
    push(tag, 1, a, e);
  endtask

  task automatic exp_epc(input string tag, input logic [31:0] e);
    push(tag, 2, 5'd0, e);
  endtask

  task automatic drain();
    sb_t ent;
    while (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      if (ent.sel == 1) addr = ent.rd_addr;
      #1;
      case (ent.sel)
        0:       chk(ent.tag, {31'd0, Req}, ent.exp);
        1:       chk(ent.tag, dout, ent.exp);
        2:       chk(ent.tag, EPCOut, ent.exp);
        default: chk(ent.tag, excPC, ent.exp);
      endcase
    end
  endtask

  // Inputs change 1 ns after a rising edge; checks run before the next edge.
  task automatic next_cycle();
    #2;
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; eretIn = 1'b0; excCodeIn = 5'd0; delaySlotIn = 1'b0;
    addr = 5'd0; din = 32'd0;
  endtask

  task automatic do_eret();
    idle();
    eretIn = 1'b1;
    next_cycle();
    idle();
  endtask

  initial begin
    reset = 1'b0; pcIn = 32'h100; HWInt = 6'h3F;
    idle();
    excCodeIn = 5'd12;
    @(posedge clk); #1;

    // Held in reset with every request source active
    exp_req("rst_req", 1'b0);
    exp_rd("rst_sr", 5'd12, 32'd0);
    exp_rd("rst_cause", 5'd13, 32'd0);
    exp_rd("rst_epc", 5'd14, 32'd0);
    push("excpc", 3, 5'd0, 32'h0000_4180);
    next_cycle();
    exp_req("rst_req2", 1'b0);
    next_cycle();

    // Release mid-cycle: ExcReq fires at once
    reset = 1'b1;
    exp_req("rel_req", 1'b1);
    next_cycle();
    exp_req("rel_exl_blk", 1'b0);
    exp_rd("rel_cause", 5'd13, 32'h0000_FC30);
    exp_rd("rel_epc", 5'd14, 32'h0000_0100);
    exp_rd("rel_sr", 5'd12, 32'h0000_0002);
    next_cycle();
    HWInt = 6'h00;
    do_eret();
    exp_rd("eret_sr", 5'd12, 32'd0);
    next_cycle();

    // Plain exception
    excCodeIn = 5'd4; pcIn = 32'h0000_3008;
    exp_req("exc4_req", 1'b1);
    next_cycle();
    exp_req("exc4_req_drop", 1'b0);
    exp_rd("exc4_epc", 5'd14, 32'h0000_3008);
    exp_rd("exc4_cause", 5'd13, 32'h0000_0010);
    exp_rd("exc4_sr", 5'd12, 32'h0000_0002);
    next_cycle();
    do_eret();

    // Delay-slot exception
    excCodeIn = 5'd10; pcIn = 32'h0000_3010; delaySlotIn = 1'b1;
    exp_req("ds_req", 1'b1);
    next_cycle();
    idle();
    exp_rd("ds_epc", 5'd14, 32'h0000_300C);
    exp_rd("ds_cause", 5'd13, 32'h8000_0028);
    next_cycle();
    do_eret();

    // Delay slot at PC 0 wraps
    excCodeIn = 5'd10; pcIn = 32'h0; delaySlotIn = 1'b1;
    next_cycle();
    idle();
    exp_rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    next_cycle();
    do_eret();

    // Enable IM[0] and IE
    we = 1'b1; addr = 5'd12; din = 32'h0000_0401;
    exp_req("mtc0_sr_req", 1'b0);
    exp_epc("epcout_nofwd", 32'hFFFF_FFFC);
    next_cycle();
    idle();
    exp_rd("sr_written", 5'd12, 32'h0000_0401);
    next_cycle();

    // Interrupt beats exception
    HWInt = 6'h01; excCodeIn = 5'd8; pcIn = 32'h0000_2000;
    exp_req("int_req", 1'b1);
    next_cycle();
    idle(); HWInt = 6'h00;
    exp_rd("int_cause", 5'd13, 32'h0000_0400);
    exp_rd("int_sr", 5'd12, 32'h0000_0403);
    exp_rd("int_epc", 5'd14, 32'h0000_2000);
    next_cycle();
    do_eret();

    // Masked line: exception taken instead
    HWInt = 6'h02; excCodeIn = 5'd8;
    exp_req("mask_req", 1'b1);
    next_cycle();
    idle(); HWInt = 6'h00;
    exp_rd("mask_cause", 5'd13, 32'h0000_0820);
    next_cycle();
    do_eret();

    // Pure interrupt, then it stays pending while EXL is set
    HWInt = 6'h01;
    exp_req("pint_req", 1'b1);
    next_cycle();
    exp_req("pint_pending", 1'b0);
    exp_rd("pint_cause", 5'd13, 32'h0000_0400);
    next_cycle();

    // EXL blocks, eret reopens
    HWInt = 6'h00; excCodeIn = 5'd12;
    exp_req("exl_blk", 1'b0);
    next_cycle();
    eretIn = 1'b1;
    exp_req("exl_eret_cyc", 1'b0);
    next_cycle();
    eretIn = 1'b0;
    exp_req("exl_reopen", 1'b1);
    next_cycle();

    // mtc0 EPC with eret in the same cycle
    idle();
    we = 1'b1; addr = 5'd14; din = 32'h0000_3ABE; eretIn = 1'b1;
    exp_req("fwd_req", 1'b0);
    exp_epc("fwd_epcout", 32'h0000_3ABC);
    next_cycle();
    idle();
    exp_rd("fwd_epc_reg", 5'd14, 32'h0000_3ABC);
    exp_rd("fwd_sr", 5'd12, 32'h0000_0401);
    exp_epc("epcout_reg", 32'h0000_3ABC);
    next_cycle();

    // mtc0 SR sets EXL together with eret: EXL ends cleared
    we = 1'b1; addr = 5'd12; din = 32'h0000_0403; eretIn = 1'b1;
    next_cycle();
    idle();
    exp_rd("sr_eret_order", 5'd12, 32'h0000_0401);
    next_cycle();

    // Cause is read-only; PRId and unmapped reads
    we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
    next_cycle();
    idle();
    exp_rd("cause_ro", 5'd13, 32'h0000_0030);
    exp_rd("prid", 5'd15, 32'h2022_1113);
    exp_rd("unmapped", 5'd3, 32'd0);
    next_cycle();

    // mtc0 squashed by an exception in the same cycle
    excCodeIn = 5'd4; pcIn = 32'h0000_0500; we = 1'b1; addr = 5'd14; din = 32'h0000_7770;
    exp_req("squash_req", 1'b1);
    exp_epc("squash_epcout", 32'h0000_7770);
    next_cycle();
    idle();
    exp_rd("squash_epc", 5'd14, 32'h0000_0500);
    next_cycle();

    // Asynchronous reset mid-cycle
    excCodeIn = 5'd5;
    reset = 1'b0;
    exp_req("async_req", 1'b0);
    exp_rd("async_sr", 5'd12, 32'd0);
    exp_rd("async_epc", 5'd14, 32'd0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
